cordic_post: RTL and testbench

CORDIC_POST -- requirements
Module: cordic_post

---
 rtl/cordic_post_if.sv | 27 ++
 rtl/cordic_post.sv | 81 ++++++++
 tb/tb_cordic_post.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cordic_post_if.sv
// Streaming bus between the CORDIC iteration core and the post-processing stage.
// The slave modport is the post-processor; the master modport is whatever feeds it.
interface cordic_post_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 16
);
    logic          din_vsync;
    logic          din_hsync;
    logic [DW-1:0] din_mag;
    logic [AW-1:0] din_ang;
    logic [2:0]    din_info;

    logic          dout_vsync;
    logic          dout_hsync;
    logic [DW-1:0] dout_mag;
    logic [AW-1:0] dout_ang;

    modport slave (
        input  din_vsync, din_hsync, din_mag, din_ang, din_info,
        output dout_vsync, dout_hsync, dout_mag, dout_ang
    );

    modport master (
        output din_vsync, din_hsync, din_mag, din_ang, din_info,
        input  dout_vsync, dout_hsync, dout_mag, dout_ang
    );
endinterface

// File: rtl/cordic_post.sv
// CORDIC post-processing: two-stage pipeline that applies gain compensation to the
// magnitude and unfolds the first-octant angle back to the full circle.
module cordic_post #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 16,
    parameter int unsigned FB = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    cordic_post_if.slave  bus
);
    localparam int unsigned MW = DW + 1;

    localparam logic [AW-1:0] A45  = AW'(45  << FB);
    localparam logic [AW-1:0] A90  = AW'(90  << FB);
    localparam logic [AW-1:0] A180 = AW'(180 << FB);
    localparam logic [AW-1:0] A360 = AW'(360 << FB);

    logic          vs1_q;
    logic          hs1_q;
    logic [AW-1:0] ang1_q, ang1_d;
    logic [DW-1:0] mag1_q, mag1_d;
    logic [1:0]    info1_q;

    logic [AW-1:0] angc_c;
    logic [MW-1:0] mag_sum_c;
    logic [AW-1:0] ang_unf_c;

    // Stage 1: clamp to the first octant, undo the x/y swap, and scale by ~1/1.6468.
    always_comb begin
        angc_c    = (bus.din_ang > A45) ? A45 : bus.din_ang;
        ang1_d    = bus.din_info[0] ? (A90 - angc_c) : angc_c;
        mag_sum_c = MW'(bus.din_mag >> 1) + MW'(bus.din_mag >> 3)
                  - MW'(bus.din_mag >> 6) - MW'(bus.din_mag >> 9);
        mag1_d    = DW'(mag_sum_c);
    end

    // Stage 2: quadrant unfold from the source-vector signs {x neg, y neg}.
    always_comb begin
        ang_unf_c = ang1_q;
        unique case (info1_q)
            2'b00: ang_unf_c = ang1_q;
            2'b10: ang_unf_c = A180 - ang1_q;
            2'b11: ang_unf_c = A180 + ang1_q;
            2'b01: ang_unf_c = (ang1_q == '0) ? '0 : (A360 - ang1_q);
            default: ang_unf_c = ang1_q;
        endcase
    end

    // Sync delay chains run freely; data stages follow the delayed line-valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs1_q          <= 1'b0;
            hs1_q          <= 1'b0;
            ang1_q         <= '0;
            mag1_q         <= '0;
            info1_q        <= '0;
            bus.dout_vsync <= 1'b0;
            bus.dout_hsync <= 1'b0;
            bus.dout_mag   <= '0;
            bus.dout_ang   <= '0;
        end else begin
            vs1_q          <= bus.din_vsync;
            hs1_q          <= bus.din_hsync;
            bus.dout_vsync <= vs1_q;
            bus.dout_hsync <= hs1_q;
            if (bus.din_hsync) begin
                ang1_q  <= ang1_d;
                mag1_q  <= mag1_d;
                info1_q <= bus.din_info[2:1];
            end
            if (hs1_q) begin
                bus.dout_ang <= ang_unf_c;
                bus.dout_mag <= mag1_q;
            end else begin
                bus.dout_ang <= '0;
                bus.dout_mag <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cordic_post.sv
// Directed-vector bench for cordic_post: streamed table of samples with
// hand-computed results, plus an asynchronous mid-burst reset sequence.
module tb_cordic_post;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned NV = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    cordic_post_if #(.DW(DW), .AW(AW)) bus ();

    cordic_post #(.DW(DW), .AW(AW), .FB(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic          vs;
        logic          hs;
        logic [DW-1:0] mag;
        logic [AW-1:0] ang;
        logic [2:0]    info;
        logic          evs;
        logic          ehs;
        logic [DW-1:0] emag;
        logic [AW-1:0] eang;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic vs, input logic hs,
                             input logic [DW-1:0] mag, input logic [AW-1:0] ang);
        check({tag, ".vsync"}, 32'(bus.dout_vsync), 32'(vs));
        check({tag, ".hsync"}, 32'(bus.dout_hsync), 32'(hs));
        check({tag, ".mag"},   32'(bus.dout_mag),   32'(mag));
        check({tag, ".ang"},   32'(bus.dout_ang),   32'(ang));
    endtask

    task automatic drive(input logic vs, input logic hs, input logic [DW-1:0] mag,
                         input logic [AW-1:0] ang, input logic [2:0] info);
        bus.din_vsync = vs;
        bus.din_hsync = hs;
        bus.din_mag   = mag;
        bus.din_ang   = ang;
        bus.din_info  = info;
    endtask

    initial begin
        //               vs    hs    mag     ang    info    evs   ehs   emag    eang
        vecs[0]  = '{1'b1, 1'b1, 16'd1000,  16'd1920,  3'b000, 1'b1, 1'b1, 16'd609,   16'd1920};
        vecs[1]  = '{1'b0, 1'b1, 16'd2000,  16'd1920,  3'b001, 1'b0, 1'b1, 16'd1216,  16'd3840};
        vecs[2]  = '{1'b0, 1'b1, 16'd100,   16'd1920,  3'b100, 1'b0, 1'b1, 16'd61,    16'd9600};
        vecs[3]  = '{1'b0, 1'b1, 16'd64,    16'd1920,  3'b110, 1'b0, 1'b1, 16'd39,    16'd13440};
        vecs[4]  = '{1'b0, 1'b1, 16'd512,   16'd1920,  3'b010, 1'b0, 1'b1, 16'd311,   16'd21120};
        vecs[5]  = '{1'b0, 1'b1, 16'd65535, 16'd0,     3'b011, 1'b0, 1'b1, 16'd39808, 16'd17280};
        vecs[6]  = '{1'b0, 1'b1, 16'd7,     16'd0,     3'b010, 1'b0, 1'b1, 16'd3,     16'd0};
        vecs[7]  = '{1'b0, 1'b1, 16'd0,     16'd4000,  3'b000, 1'b0, 1'b1, 16'd0,     16'd2880};
        vecs[8]  = '{1'b1, 1'b0, 16'd1234,  16'd1000,  3'b111, 1'b1, 1'b0, 16'd0,     16'd0};
        vecs[9]  = '{1'b0, 1'b0, 16'd999,   16'd500,   3'b101, 1'b0, 1'b0, 16'd0,     16'd0};
        vecs[10] = '{1'b0, 1'b1, 16'd1000,  16'd65535, 3'b101, 1'b0, 1'b1, 16'd609,   16'd8640};
        vecs[11] = '{1'b0, 1'b1, 16'd1000,  16'd2880,  3'b001, 1'b0, 1'b1, 16'd609,   16'd2880};
        vecs[12] = '{1'b0, 1'b1, 16'd1000,  16'd0,     3'b001, 1'b0, 1'b1, 16'd609,   16'd5760};
        vecs[13] = '{1'b0, 1'b1, 16'd1000,  16'd2880,  3'b011, 1'b0, 1'b1, 16'd609,   16'd20160};

        // Reset state with live-looking inputs present.
        drive(1'b1, 1'b1, 16'd1000, 16'd1920, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 3'b000);
        rst_n = 1'b1;

        // Streamed table: sample i driven after edge i, checked after edge i+2.
        for (int i = 0; i < int'(NV) + 2; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2)
                check_out($sformatf("vec%0d", i - 2), vecs[i-2].evs, vecs[i-2].ehs,
                          vecs[i-2].emag, vecs[i-2].eang);
            if (i < int'(NV))
                drive(vecs[i].vs, vecs[i].hs, vecs[i].mag, vecs[i].ang, vecs[i].info);
            else
                drive(1'b0, 1'b0, '0, '0, 3'b000);
        end

        // Valid burst, then asynchronous reset in the middle of the line.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            drive(1'b1, 1'b1, 16'd1000, 16'd1920, 3'b000);
        end
        @(posedge clk);
        #1;
        check_out("burst", 1'b1, 1'b1, 16'd609, 16'd1920);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b0, '0, '0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // First valid sample after release appears exactly two edges later.
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 16'd2000, 16'd1920, 3'b110);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, '0, '0, 3'b000);
        check_out("post_rst_1", 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        check_out("post_rst_2", 1'b0, 1'b1, 16'd1216, 16'd13440);
        @(posedge clk);
        #1;
        check_out("post_rst_3", 1'b0, 1'b0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
